// File: rtl/vd6_pkg.sv
// Shared types and widths for the vd6 multiply-accumulate stage.
package vd6_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int CNT_W = 5;
    localparam int P_W   = 8;
endpackage

// File: rtl/vd5.sv
// 4x4 unsigned combinational multiplier, built as a shift-and-add of partial products.
module vd5
    import vd6_pkg::*;
(
    input  logic [3:0]     m,
    input  logic [3:0]     q,
    output logic [P_W-1:0] p
);
    always_comb begin
        p = '0;
        for (int i = 0; i < 4; i++) begin
            if (q[i]) begin
                p = p + (P_W'(m) << i);
            end
        end
    end
endmodule

// File: rtl/vd6_mac.sv
// Burst multiply-accumulate: sums N products from vd5 into a saturating accumulator
// and holds the burst total on an output handshake until downstream takes it.
module vd6_mac
    import vd6_pkg::*;
#(
    parameter int N     = 8,
    parameter int ACC_W = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       m,
    input  logic [3:0]       q,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] acc,
    output logic             ovf,
    output logic [CNT_W-1:0] cnt
);
    // Valid/ready: a transfer occurs on a rising edge where valid and ready are both
    // high; ready and valid are decoded from state only and never look at the partner.
    state_t           state;
    state_t           state_next;
    logic [P_W-1:0]   p;
    logic             accept;
    logic             release_out;
    logic [ACC_W:0]   sum_ext;
    logic [CNT_W-1:0] cnt_inc;

    vd5 u_vd5 (
        .m (m),
        .q (q),
        .p (p)
    );

    always_comb begin
        state_next  = state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        sum_ext     = {1'b0, acc} + (ACC_W + 1)'(p);
        cnt_inc     = cnt + 1'b1;
        case (state)
            IDLE:    in_ready  = !rst;
            ACC:     in_ready  = !rst;
            DONE:    out_valid = 1'b1;
            default: in_ready  = 1'b0;
        endcase
        accept      = in_valid && in_ready;
        release_out = out_valid && out_ready;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = (N == 1) ? DONE : ACC;
                end
            end
            ACC: begin
                if (accept && (cnt_inc == CNT_W'(N))) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (release_out) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
            ovf   <= 1'b0;
        end else begin
            state <= state_next;
            if (accept && (state == IDLE)) begin
                acc <= ACC_W'(p);
                cnt <= CNT_W'(1);
                ovf <= 1'b0;
            end else if (accept) begin
                // Carry out of the accumulator width pins the sum at full scale.
                if (sum_ext[ACC_W]) begin
                    acc <= '1;
                    ovf <= 1'b1;
                end else begin
                    acc <= sum_ext[ACC_W-1:0];
                end
                cnt <= cnt_inc;
            end else if (release_out) begin
                acc <= '0;
                cnt <= '0;
            end
        end
    end
endmodule

// File: tb/tb_vd6_mac.sv
// Bench for vd6_mac: two instances (N=8/ACC_W=12 and N=4/ACC_W=8) against a burst-sum model.
module tb_vd6_mac;
    localparam int N_A = 8;
    localparam int W_A = 12;
    localparam int N_B = 4;
    localparam int W_B = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid[2];
    logic           in_ready[2];
    logic           out_valid[2];
    logic           out_ready[2];
    logic           ovf[2];
    logic [3:0]     m[2];
    logic [3:0]     q[2];
    logic [4:0]     cnt[2];
    logic [W_A-1:0] acc_a;
    logic [W_B-1:0] acc_b;

    int  vectors     = 0;
    int  miscompares = 0;
    bit  chk_en      = 1'b0;
    int  n_of[2]     = '{N_A, N_B};
    int  max_of[2]   = '{(1 << W_A) - 1, (1 << W_B) - 1};
    int  mdl_cnt[2];
    int  mdl_sum[2];
    bit  mdl_done[2];
    bit  mdl_ovf[2];
    logic [15:0] exp_q_a[$];
    logic [15:0] exp_q_b[$];

    always #5 clk = ~clk;

    vd6_mac #(.N(N_A), .ACC_W(W_A)) u_a (
        .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .m(m[0]), .q(q[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .acc(acc_a), .ovf(ovf[0]), .cnt(cnt[0])
    );

    vd6_mac #(.N(N_B), .ACC_W(W_B)) u_b (
        .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .m(m[1]), .q(q[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .acc(acc_b), .ovf(ovf[1]), .cnt(cnt[1])
    );

    task automatic chk(input string name, input int k, input logic [31:0] act,
                       input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s[%0d] at %0t: got %0d expected %0d", name, k, $time, act, exp);
        end
    endtask

    function automatic logic [31:0] acc_of(input int k);
        return (k == 0) ? 32'(acc_a) : 32'(acc_b);
    endfunction

    // Burst-sum reference: products summed with clamping at full scale.
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            int p;
            p = int'(m[k]) * int'(q[k]);
            if (rst) begin
                mdl_done[k] = 1'b0;
                mdl_cnt[k]  = 0;
                mdl_sum[k]  = 0;
                mdl_ovf[k]  = 1'b0;
            end else if (mdl_done[k]) begin
                if (out_ready[k]) begin
                    mdl_done[k] = 1'b0;
                    mdl_cnt[k]  = 0;
                    mdl_sum[k]  = 0;
                end
            end else if (in_valid[k]) begin
                if (mdl_cnt[k] == 0) begin
                    mdl_sum[k] = p;
                    mdl_ovf[k] = 1'b0;
                end else if (mdl_sum[k] + p > max_of[k]) begin
                    mdl_sum[k] = max_of[k];
                    mdl_ovf[k] = 1'b1;
                end else begin
                    mdl_sum[k] = mdl_sum[k] + p;
                end
                mdl_cnt[k] = mdl_cnt[k] + 1;
                if (mdl_cnt[k] == n_of[k]) begin
                    mdl_done[k] = 1'b1;
                    if (k == 0) exp_q_a.push_back(16'(mdl_sum[k]));
                    else        exp_q_b.push_back(16'(mdl_sum[k]));
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 2; k++) begin
                logic [15:0] e;
                chk("in_ready", k, 32'(in_ready[k]), 32'(!rst && !mdl_done[k]));
                chk("out_valid", k, 32'(out_valid[k]), 32'(mdl_done[k]));
                chk("acc", k, acc_of(k), 32'(mdl_sum[k]));
                chk("ovf", k, 32'(ovf[k]), 32'(mdl_ovf[k]));
                chk("cnt", k, 32'(cnt[k]), 32'(mdl_cnt[k]));
                if (in_valid[k]) begin
                    chk("p", k, (k == 0) ? 32'(u_a.p) : 32'(u_b.p), 32'(int'(m[k]) * int'(q[k])));
                end
                if (mdl_done[k] && out_ready[k] && !rst) begin
                    if (k == 0 && exp_q_a.size() > 0) begin
                        e = exp_q_a.pop_front();
                        chk("result", k, acc_of(k), 32'(e));
                    end else if (k == 1 && exp_q_b.size() > 0) begin
                        e = exp_q_b.pop_front();
                        chk("result", k, acc_of(k), 32'(e));
                    end else begin
                        chk("result_queue", k, 32'd0, 32'd1);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int k, input logic [3:0] mm, input logic [3:0] qq);
        bit ok;
        bit rdy;
        ok = 1'b0;
        in_valid[k] = 1'b1;
        m[k] = mm;
        q[k] = qq;
        for (int i = 0; i < 64; i++) begin
            rdy = !rst && !mdl_done[k];
            tick();
            if (rdy) begin
                ok = 1'b1;
                break;
            end
        end
        in_valid[k] = 1'b0;
        m[k] = 4'($urandom);
        q[k] = 4'($urandom);
        if (!ok) chk("send_timeout", k, 32'd0, 32'd1);
    endtask

    task automatic take(input int k);
        out_ready[k] = 1'b1;
        tick();
        out_ready[k] = 1'b0;
    endtask

    task automatic soak(input int k);
        for (int b = 0; b < 20; b++) begin
            for (int i = 0; i < n_of[k]; i++) begin
                out_ready[k] = 1'($urandom_range(0, 1));
                repeat ($urandom_range(0, 2)) tick();
                send(k, 4'($urandom), 4'($urandom));
            end
            out_ready[k] = 1'b0;
            repeat ($urandom_range(0, 4)) begin
                in_valid[k] = 1'($urandom_range(0, 1));
                m[k] = 4'($urandom);
                q[k] = 4'($urandom);
                tick();
            end
            in_valid[k] = 1'b0;
            take(k);
        end
    endtask

    initial begin
        logic [3:0] gm[8] = '{4'd2, 4'd4, 4'd7, 4'd0, 4'd15, 4'd6, 4'd8, 4'd3};
        logic [3:0] gq[8] = '{4'd3, 4'd5, 4'd7, 4'd9, 4'd1, 4'd6, 4'd8, 4'd11};
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            in_valid[k] = 1'b0;
            out_ready[k] = 1'b0;
            m[k] = 4'd0;
            q[k] = 4'd0;
        end
        tick();
        tick();
        chk("rst_in_ready", 0, 32'(in_ready[0]), 32'd0);
        chk("rst_out_valid", 0, 32'(out_valid[0]), 32'd0);
        chk("rst_acc", 0, acc_of(0), 32'd0);
        chk("rst_cnt", 0, 32'(cnt[0]), 32'd0);
        chk("rst_ovf", 1, 32'(ovf[1]), 32'd0);
        rst = 1'b0;
        chk_en = 1'b1;

        // Full scale, then backpressure while the result is held.
        for (int i = 0; i < N_A; i++) begin
            if (i == N_A - 1) chk("early_valid", 0, 32'(out_valid[0]), 32'd0);
            send(0, 4'd15, 4'd15);
        end
        chk("full_valid", 0, 32'(out_valid[0]), 32'd1);
        chk("full_acc", 0, acc_of(0), 32'd1800);
        chk("full_ovf", 0, 32'(ovf[0]), 32'd0);
        chk("full_cnt", 0, 32'(cnt[0]), 32'd8);
        in_valid[0] = 1'b1;
        m[0] = 4'd3;
        q[0] = 4'd3;
        repeat (5) begin
            tick();
            chk("bp_acc", 0, acc_of(0), 32'd1800);
            chk("bp_in_ready", 0, 32'(in_ready[0]), 32'd0);
        end
        in_valid[0] = 1'b0;
        take(0);
        chk("rel_acc", 0, acc_of(0), 32'd0);
        chk("rel_cnt", 0, 32'(cnt[0]), 32'd0);
        chk("rel_valid", 0, 32'(out_valid[0]), 32'd0);

        // Saturation on the narrow instance; ovf persists into IDLE.
        for (int i = 0; i < N_B; i++) send(1, 4'd15, 4'd15);
        chk("sat_acc", 1, acc_of(1), 32'd255);
        chk("sat_ovf", 1, 32'(ovf[1]), 32'd1);
        take(1);
        chk("sat_ovf_idle", 1, 32'(ovf[1]), 32'd1);
        for (int i = 0; i < N_B; i++) send(1, 4'd1, 4'd1);
        chk("small_acc", 1, acc_of(1), 32'd4);
        chk("small_ovf", 1, 32'(ovf[1]), 32'd0);
        take(1);

        for (int i = 0; i < 8; i++) begin
            repeat ($urandom_range(0, 3)) tick();
            send(0, gm[i], gq[i]);
        end
        chk("gap_acc", 0, acc_of(0), 32'd223);
        take(0);

        // Reset mid-burst discards the partial sum.
        for (int i = 0; i < 3; i++) send(0, 4'd15, 4'd15);
        rst = 1'b1;
        tick();
        chk("mid_rst_acc", 0, acc_of(0), 32'd0);
        chk("mid_rst_cnt", 0, 32'(cnt[0]), 32'd0);
        chk("mid_rst_valid", 0, 32'(out_valid[0]), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < N_A; i++) send(0, 4'd2, 4'd2);
        chk("post_rst_acc", 0, acc_of(0), 32'd32);
        take(0);

        fork
            soak(0);
            soak(1);
        join
        tick();
        chk("drain_a", 0, 32'(exp_q_a.size()), 32'd0);
        chk("drain_b", 1, 32'(exp_q_b.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: bench did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
